powlib_busarb: RTL and testbench
================================

# powlib_busarb

Single-clock N-to-1 bus arbitration lane: the next generation of the bus-crossing lane. It accepts up to B_WRS address/data request streams, admits only requests whose address falls in the lane's window, and selects among them with fixed-priority or round-robin arbitration plus optional burst hold. Selected beats go through a 2-entry output buffer, giving one beat per cycle with no combinational path from rdrdy to wrrdys. Intended for the synchronous lanes of the bus crossbar and for stand-alone multi-master-to-one-slave merges.

## Interface
- B_WRS, 4, number of input channels (>=1)
- B_AW, 2, address width
- B_DW, 4, data width
- B_BASE, 0, lowest address in window
- B_SIZE, 2, window span; window is B_BASE..B_BASE+B_SIZE inclusive, sum computed in B_AW bits
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- B_BURST, 1, max consecutive beats held by one winner in MODE 1 (>=1)
- B_SW, localparam, clog2(B_WRS), minimum 1
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wrdatas  in  B_WRS*B_DW  input data, channel i at [i*B_DW+:B_DW]
- wraddrs  in  B_WRS*B_AW  input addresses, channel i at [i*B_AW+:B_AW]
- wrvlds  in  B_WRS  input valids
- wrrdys  out  B_WRS  input readies, one-hot or zero
- rddata  out  B_DW  output data
- rdaddr  out  B_AW  output address
- rdsrc  out  B_SW  index of the input channel that produced the output beat
- rdvld  out  1  output valid
- rdrdy  in  1  output ready

## Operation
- Eligible(i) = wrvlds[i] && B_BASE <= wraddrs[i] <= B_BASE+B_SIZE. Ineligible requests are never granted and never dropped. They wait with wrrdys[i]=0.
- Space = buffer count < 2. It depends only on registered state.
- Grant: when Space and any channel is eligible, exactly one wrrdys[g] is asserted. The beat transfers on wrvlds[g] && wrrdys[g].
- MODE 0: g = lowest eligible index. B_BURST is ignored.
- MODE 1: g = first eligible index scanning from pointer ptr upward, wrapping at B_WRS.
- Hold (MODE 1): while holdcnt>0 and the holder is still eligible, the holder keeps the grant.
  - holdcnt loads B_BURST-1 on the first beat of a grant and decrements per accepted beat.
  - When holdcnt reaches 0 or the holder becomes ineligible, ptr = (holder+1) mod B_WRS and the next grant is re-arbitrated.
  - With B_BURST=1 this is pure round-robin: ptr advances past the winner on every accepted beat.
- Output buffer: 2-entry FIFO of {data, addr, src}. It pushes on an accepted beat and pops on rdvld && rdrdy. Push and pop may occur in the same cycle; count is unchanged.
- rdvld = count != 0. rddata/rdaddr/rdsrc present the head entry and hold stable while rdvld && !rdrdy.

## Timing
- Reset: rdvld=0, wrrdys=0 during the rst cycle, count=0, ptr=0, holdcnt=0, no hold active. rddata/rdaddr/rdsrc are don't-care (not reset).
- Reset mid-operation discards buffered beats. Beats presented during rst are not accepted.
- Latency: a beat accepted at edge N appears on the outputs with rdvld=1 after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while rdrdy=1.
- With rdrdy stuck at 0, exactly 2 beats are accepted and then all wrrdys=0.
- Arbitration updates (ptr, holdcnt) occur only on accepted beats. A grant offered without a transfer cannot happen, because wrrdys is gated by eligibility.
- Full window (B_BASE=0, B_SIZE=all ones) admits every address. Wrap of B_BASE+B_SIZE is not checked and is the user's responsibility.

## Structure
- A shared bus header/package holds the MODE encodings (POWLIB_ARB_FIXED=0, POWLIB_ARB_RR=1) and the clog2 function used for B_SW.
- Sub-module powlib_rrarb: combinational request vector plus ptr to one-hot grant and encoded index. It is reused for the MODE 0 case with ptr tied to 0.
- Output buffer is built inline as a 2-entry register file with count, or as powlib_swissfifo with D=2, S=0.

## Test plan
- Round-robin fairness: MODE=1, B_BURST=1, all 4 channels continuously valid with in-window addresses, rdrdy=1 -> rdsrc sequence 0,1,2,3,0,1,… one beat per cycle, first rdvld one cycle after rst deasserts.
- Burst hold: MODE=1, B_BURST=3, channels 0 and 2 always valid -> rdsrc 0,0,0,2,2,2,0,… Channel 0 dropping valid after 1 beat -> grant moves to 2 immediately.
- Fixed priority: MODE=0, channels 1 and 3 valid -> only channel 1 is served until it deasserts, then channel 3.
- Window filter: B_BASE=1, B_SIZE=1; channel 0 addr=0, channel 1 addr=2 -> channel 0 never gets wrrdys, channel 1 beats pass with rdaddr=2, rdsrc=1.
- Backpressure: rdrdy=0 for 5 cycles with all channels valid -> exactly 2 beats accepted, outputs stable. Releasing rdrdy -> the 2 buffered beats drain in order, with no loss or duplication.
- Reset mid-stream: rst asserted with count=2 -> next cycle rdvld=0, ptr=0. The first post-reset grant goes to the lowest eligible index.

Source files
------------

// File: rtl/powlib_busarb_pkg.sv
// Shared definitions for the powlib bus lanes: arbitration mode encodings
// and the index-width helper used to size channel-select fields.
package powlib_busarb_pkg;

    localparam int POWLIB_ARB_FIXED = 0;
    localparam int POWLIB_ARB_RR    = 1;

    // Ceiling log2 with a floor of 1 so that a single-channel lane still
    // gets a one-bit index field.
    function automatic int powlib_clog2(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < value) begin
                result = r + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/powlib_rrarb.sv
// Combinational rotating-priority arbiter: scans the request vector
// starting at ptr, wrapping at N, and returns the first requester as a
// one-hot grant plus its encoded index. Tie ptr to 0 for fixed priority.
module powlib_rrarb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] scan;

    // Walk the channels in priority order from ptr and keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        scan  = '0;
        for (int k = 0; k < N; k++) begin
            scan = W'((int'(ptr) + k) % N);
            if (!any && req[scan]) begin
                grant[scan] = 1'b1;
                idx         = scan;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/powlib_busarb.sv
// N-to-1 bus arbitration lane: window-filters incoming requests, picks one
// per cycle by fixed priority or round-robin with burst hold, and passes
// the winner through a 2-entry output buffer so rdrdy never reaches wrrdys.
module powlib_busarb
    import powlib_busarb_pkg::*;
#(
    parameter int B_WRS   = 4,
    parameter int B_AW    = 2,
    parameter int B_DW    = 4,
    parameter int B_BASE  = 0,
    parameter int B_SIZE  = 2,
    parameter int MODE    = 1,
    parameter int B_BURST = 1,
    localparam int B_SW   = powlib_clog2(B_WRS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [B_WRS*B_DW-1:0]   wrdatas,
    input  logic [B_WRS*B_AW-1:0]   wraddrs,
    input  logic [B_WRS-1:0]        wrvlds,
    output logic [B_WRS-1:0]        wrrdys,
    output logic [B_DW-1:0]         rddata,
    output logic [B_AW-1:0]         rdaddr,
    output logic [B_SW-1:0]         rdsrc,
    output logic                    rdvld,
    input  logic                    rdrdy
);

    localparam int HW = powlib_clog2(B_BURST);
    localparam logic [B_AW-1:0] WIN_LO   = B_AW'(B_BASE);
    localparam logic [B_AW-1:0] WIN_SPAN = B_AW'(B_SIZE);
    localparam logic            RR_MODE  = (MODE == POWLIB_ARB_RR);

    logic [B_WRS-1:0] eligible;
    logic [B_WRS-1:0] arb_req;
    logic [B_SW-1:0]  arb_ptr;
    logic [B_WRS-1:0] grant;
    logic [B_SW-1:0]  gnt_idx;
    logic             gnt_any;
    logic [B_SW-1:0]  next_ptr;

    logic [B_SW-1:0]  ptr;
    logic [B_SW-1:0]  holder;
    logic [HW-1:0]    holdcnt;
    logic             hold_keep;

    logic [1:0]       count;
    logic             wr_sel;
    logic             rd_sel;
    logic             space;
    logic             accept;
    logic             pop;

    logic [B_DW-1:0]  buf_data [2];
    logic [B_AW-1:0]  buf_addr [2];
    logic [B_SW-1:0]  buf_src  [2];

    // A request is eligible when valid and its address offset from the
    // window base lies within the span; the B_AW-bit subtraction keeps the
    // window arithmetic in address width.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < B_WRS; i++) begin
            eligible[i] = wrvlds[i] &&
                          ((wraddrs[i*B_AW +: B_AW] - WIN_LO) <= WIN_SPAN);
        end
    end

    // An active burst holder overrides arbitration by presenting itself as
    // the sole requester; otherwise the arbiter scans from ptr (or 0).
    always_comb begin
        hold_keep = RR_MODE && (holdcnt != '0) && eligible[holder];
        arb_req   = hold_keep ? (B_WRS'(1) << holder) : eligible;
        arb_ptr   = RR_MODE ? (hold_keep ? holder : ptr) : '0;
    end

    powlib_rrarb #(
        .N (B_WRS),
        .W (B_SW)
    ) u_rrarb (
        .req   (arb_req),
        .ptr   (arb_ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grants are offered only with buffer space and outside reset, so any
    // asserted ready is always matched by a valid and becomes a transfer.
    always_comb begin
        space    = (count != 2'd2);
        wrrdys   = (space && !rst) ? grant : '0;
        accept   = space && !rst && gnt_any;
        pop      = (count != 2'd0) && rdrdy;
        next_ptr = (gnt_idx == B_SW'(B_WRS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Round-robin pointer and burst counter move only on accepted beats;
    // ptr always sits just past the last winner so a broken hold rescans
    // from holder+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            holder  <= '0;
            holdcnt <= '0;
        end else if (accept && RR_MODE) begin
            ptr <= next_ptr;
            if (hold_keep) begin
                holdcnt <= holdcnt - 1'b1;
            end else begin
                holdcnt <= HW'(B_BURST - 1);
                holder  <= gnt_idx;
            end
        end
    end

    // Output buffer occupancy and read/write slot pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (accept) begin
                wr_sel <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            if (accept && !pop) begin
                count <= count + 2'd1;
            end else if (!accept && pop) begin
                count <= count - 2'd1;
            end
        end
    end

    // Buffer payload storage; contents are don't-care until count says so.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data[wr_sel] <= wrdatas[gnt_idx*B_DW +: B_DW];
            buf_addr[wr_sel] <= wraddrs[gnt_idx*B_AW +: B_AW];
            buf_src[wr_sel]  <= gnt_idx;
        end
    end

    // Head of the buffer drives the read side.
    always_comb begin
        rdvld  = (count != 2'd0);
        rddata = buf_data[rd_sel];
        rdaddr = buf_addr[rd_sel];
        rdsrc  = buf_src[rd_sel];
    end

endmodule

// File: tb/tb_powlib_busarb.sv
// Directed bench for powlib_busarb: three lanes share one stimulus bus --
// round-robin, round-robin with 3-beat bursts, and fixed priority with a
// narrowed address window -- and each phase checks the relevant lane.
module tb_powlib_busarb;

    logic        clk;
    logic        rst;
    logic [15:0] wrdatas;
    logic [7:0]  wraddrs;
    logic [3:0]  wrvlds;
    logic        rdrdy;

    logic [3:0] wrrdys_rr, wrrdys_bu, wrrdys_fx;
    logic [3:0] rddata_rr, rddata_bu, rddata_fx;
    logic [1:0] rdaddr_rr, rdaddr_bu, rdaddr_fx;
    logic [1:0] rdsrc_rr,  rdsrc_bu,  rdsrc_fx;
    logic       rdvld_rr,  rdvld_bu,  rdvld_fx;

    int checks;
    int errors;

    // Channel i carries data 5+i; address tables per phase, packed {ch3..ch0}.
    localparam logic [15:0] DATA_ALL = 16'h8765;
    localparam logic [7:0]  ADDR_A   = {2'd2, 2'd2, 2'd1, 2'd0};
    localparam logic [7:0]  ADDR_B   = {2'd1, 2'd0, 2'd2, 2'd0};

    logic [1:0] rr_addr_tbl [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [1:0] burst_exp   [7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};

    powlib_busarb #(.MODE(1), .B_BURST(1)) u_rr (
        .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs),
        .wrvlds(wrvlds), .wrrdys(wrrdys_rr), .rddata(rddata_rr),
        .rdaddr(rdaddr_rr), .rdsrc(rdsrc_rr), .rdvld(rdvld_rr), .rdrdy(rdrdy)
    );

    powlib_busarb #(.MODE(1), .B_BURST(3)) u_bu (
        .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs),
        .wrvlds(wrvlds), .wrrdys(wrrdys_bu), .rddata(rddata_bu),
        .rdaddr(rdaddr_bu), .rdsrc(rdsrc_bu), .rdvld(rdvld_bu), .rdrdy(rdrdy)
    );

    powlib_busarb #(.MODE(0), .B_BASE(1), .B_SIZE(1)) u_fx (
        .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs),
        .wrvlds(wrvlds), .wrrdys(wrrdys_fx), .rddata(rddata_fx),
        .rdaddr(rdaddr_fx), .rdsrc(rdsrc_fx), .rdvld(rdvld_fx), .rdrdy(rdrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [3:0] vlds, input logic rdy);
        rst    = r;
        wrvlds = vlds;
        rdrdy  = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        wrdatas = DATA_ALL;
        wraddrs = ADDR_A;
        applyStimulus(1'b1, 4'hF, 1'b1);

        // Reset: nothing valid, no readies even with all requests up.
        @(negedge clk);
        checkOutput("rst_rdvld_rr", rdvld_rr, 0);
        checkOutput("rst_rdvld_bu", rdvld_bu, 0);
        checkOutput("rst_rdvld_fx", rdvld_fx, 0);
        checkOutput("rst_wrrdys_rr", wrrdys_rr, 0);
        checkOutput("rst_wrrdys_bu", wrrdys_bu, 0);

        // Round-robin fairness, one beat per cycle.
        applyStimulus(1'b0, 4'hF, 1'b1);
        #1 checkOutput("rr_first_grant", wrrdys_rr, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_vld_%0d", k), rdvld_rr, 1);
            checkOutput($sformatf("rr_src_%0d", k), rdsrc_rr, k % 4);
            checkOutput($sformatf("rr_data_%0d", k), rddata_rr, 5 + (k % 4));
            checkOutput($sformatf("rr_addr_%0d", k), rdaddr_rr, rr_addr_tbl[k % 4]);
        end

        // Burst hold with channels 0 and 2.
        @(negedge clk);
        applyStimulus(1'b1, 4'b0101, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0101, 1'b1);
        #1 checkOutput("bu_first_grant", wrrdys_bu, 4'b0001);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bu_src_%0d", k), rdsrc_bu, burst_exp[k]);
            checkOutput($sformatf("bu_vld_%0d", k), rdvld_bu, 1);
        end
        // Channel 0 drops right after the first beat of its burst.
        applyStimulus(1'b0, 4'b0100, 1'b1);
        #1 checkOutput("bu_drop_grant", wrrdys_bu, 4'b0100);
        @(negedge clk);
        checkOutput("bu_drop_src", rdsrc_bu, 2);
        checkOutput("bu_drop_data", rddata_bu, 7);

        // Fixed priority with window 1..2; channel 0 sits at address 0.
        @(negedge clk);
        wraddrs = ADDR_B;
        applyStimulus(1'b1, 4'b1011, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'b1011, 1'b1);
        #1 checkOutput("fx_first_grant", wrrdys_fx, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("fx_src_%0d", k), rdsrc_fx, 1);
            checkOutput($sformatf("fx_addr_%0d", k), rdaddr_fx, 2);
            checkOutput($sformatf("fx_data_%0d", k), rddata_fx, 6);
            checkOutput($sformatf("fx_rdys_%0d", k), wrrdys_fx, 4'b0010);
        end
        applyStimulus(1'b0, 4'b1001, 1'b1);
        #1 checkOutput("fx_ch3_grant", wrrdys_fx, 4'b1000);
        @(negedge clk);
        checkOutput("fx_ch3_src", rdsrc_fx, 3);
        checkOutput("fx_ch3_addr", rdaddr_fx, 1);
        checkOutput("fx_ch3_data", rddata_fx, 8);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        #1 checkOutput("fx_window_block", wrrdys_fx, 4'b0000);
        @(negedge clk);
        checkOutput("fx_window_empty", rdvld_fx, 0);
        checkOutput("fx_window_still", wrrdys_fx, 4'b0000);

        // Backpressure: two beats then full, head held stable.
        @(negedge clk);
        wraddrs = ADDR_A;
        applyStimulus(1'b1, 4'hF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'hF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_vld_%0d", k), rdvld_rr, 1);
            checkOutput($sformatf("bp_src_%0d", k), rdsrc_rr, 0);
            checkOutput($sformatf("bp_data_%0d", k), rddata_rr, 5);
            checkOutput($sformatf("bp_addr_%0d", k), rdaddr_rr, 0);
            checkOutput($sformatf("bp_rdys_%0d", k), wrrdys_rr, (k == 0) ? 4'b0010 : 4'b0000);
        end
        applyStimulus(1'b0, 4'hF, 1'b1);
        @(negedge clk);
        checkOutput("drain_src_1", rdsrc_rr, 1);
        checkOutput("drain_data_1", rddata_rr, 6);
        checkOutput("drain_rdys_1", wrrdys_rr, 4'b0100);
        @(negedge clk);
        checkOutput("drain_src_2", rdsrc_rr, 2);
        checkOutput("drain_data_2", rddata_rr, 7);

        // Fill again with the pointer away from 0, then reset mid-stream.
        applyStimulus(1'b0, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("refill_src", rdsrc_rr, 2);
        checkOutput("refill_full", wrrdys_rr, 4'b0000);
        applyStimulus(1'b0, 4'hF, 1'b1);
        @(negedge clk);
        checkOutput("refill_src3", rdsrc_rr, 3);
        checkOutput("refill_rdys", wrrdys_rr, 4'b0001);
        applyStimulus(1'b0, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_vld", rdvld_rr, 1);
        checkOutput("pre_rst_full", wrrdys_rr, 4'b0000);
        applyStimulus(1'b1, 4'hF, 1'b0);
        @(negedge clk);
        checkOutput("mid_rst_vld", rdvld_rr, 0);
        applyStimulus(1'b0, 4'hF, 1'b1);
        #1 checkOutput("post_rst_grant", wrrdys_rr, 4'b0001);
        @(negedge clk);
        checkOutput("post_rst_vld", rdvld_rr, 1);
        checkOutput("post_rst_src", rdsrc_rr, 0);
        checkOutput("post_rst_data", rddata_rr, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
